// File: rtl/traffic_monitor.sv
// Traffic light protocol monitor: decodes lamp patterns, checks phase sequencing and
// counts light cycles. Optional dwell-time checking is enabled by TRAFFIC_MON_DWELL_CHECK_EN.
module traffic_monitor #(
    parameter int unsigned MAX_DWELL = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       red,
    input  logic       amb,
    input  logic       gre,
    input  logic       clr,
    output logic [2:0] phase,
    output logic       err,
    output logic [1:0] err_code,
    output logic       err_pulse,
    output logic [7:0] cycles
);

    typedef enum logic {
        WAIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        PH_DARK    = 3'd0,
        PH_RED     = 3'd1,
        PH_RED_AMB = 3'd2,
        PH_GREEN   = 3'd3,
        PH_AMBER   = 3'd4,
        PH_ILLEGAL = 3'd7
    } phase_t;

    if (MAX_DWELL < 2 || MAX_DWELL > 255) begin : g_bad_max_dwell
        $error("MAX_DWELL must lie in 2..255");
    end

    function automatic phase_t succ(input phase_t p);
        case (p)
            PH_DARK:    succ = PH_RED;
            PH_RED:     succ = PH_RED_AMB;
            PH_RED_AMB: succ = PH_GREEN;
            PH_GREEN:   succ = PH_AMBER;
            PH_AMBER:   succ = PH_RED;
            default:    succ = PH_ILLEGAL;
        endcase
    endfunction

    state_t     state_q, state_d;
    phase_t     phase_q, cur;
    logic       err_q, err_pulse_q;
    logic [1:0] err_code_q, viol;
    logic [7:0] cycles_q;
    logic       cyc_inc;

`ifdef TRAFFIC_MON_DWELL_CHECK_EN
    localparam logic [7:0] DWELL_LIMIT = 8'(MAX_DWELL);
    logic [7:0] dwell_q, dwell_d;
    logic       dwell_viol;
`endif

    always_comb begin
        case ({red, amb, gre})
            3'b000:  cur = PH_DARK;
            3'b100:  cur = PH_RED;
            3'b110:  cur = PH_RED_AMB;
            3'b001:  cur = PH_GREEN;
            3'b010:  cur = PH_AMBER;
            default: cur = PH_ILLEGAL;
        endcase

        state_d = state_q;
        viol    = 2'd0;
        cyc_inc = 1'b0;
        if (cur == PH_ILLEGAL) begin
            viol    = 2'd1;
            state_d = WAIT;
        end else if (state_q == WAIT) begin
            if (cur == PH_DARK || cur == PH_RED) state_d = TRACK;
            else                                 viol    = 2'd2;
        end else if (cur != phase_q && cur != succ(phase_q)) begin
            viol = 2'd2;
        end else if (phase_q == PH_AMBER && cur == PH_RED) begin
            cyc_inc = 1'b1;
        end

`ifdef TRAFFIC_MON_DWELL_CHECK_EN
        // Dwell only accumulates while a lit phase repeats, so it never collides with code 2
        // except in WAIT, where the transition error keeps priority.
        dwell_d    = dwell_q;
        dwell_viol = 1'b0;
        if (cur == PH_DARK || cur == PH_ILLEGAL) begin
            dwell_d = '0;
        end else if (cur != phase_q) begin
            dwell_d = 8'd1;
        end else if (dwell_q >= DWELL_LIMIT) begin
            dwell_viol = 1'b1;
            dwell_d    = 8'd1;
        end else begin
            dwell_d = dwell_q + 8'd1;
        end
        if (viol == 2'd0 && dwell_viol) viol = 2'd3;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT;
            phase_q     <= PH_DARK;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_pulse_q <= 1'b0;
            cycles_q    <= '0;
`ifdef TRAFFIC_MON_DWELL_CHECK_EN
            dwell_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= cur;
            err_pulse_q <= (viol != 2'd0);
            if (viol != 2'd0) begin
                err_q <= 1'b1;
                if (!err_q || clr) err_code_q <= viol;
            end else if (clr) begin
                err_q      <= 1'b0;
                err_code_q <= '0;
            end
            if (cyc_inc) cycles_q <= cycles_q + 8'd1;
`ifdef TRAFFIC_MON_DWELL_CHECK_EN
            dwell_q     <= dwell_d;
`endif
        end
    end

    assign phase     = phase_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_pulse = err_pulse_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: a behavioural model pushes expected outputs per
// sample, a monitor pops and compares after each clock edge.
module tb_traffic_monitor;

    localparam int MAXD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       red = 1'b0, amb = 1'b0, gre = 1'b0, clr = 1'b0;
    logic [2:0] phase;
    logic       err;
    logic [1:0] err_code;
    logic       err_pulse;
    logic [7:0] cycles;

    always #5 clk = ~clk;

    traffic_monitor #(.MAX_DWELL(MAXD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .red      (red),
        .amb      (amb),
        .gre      (gre),
        .clr      (clr),
        .phase    (phase),
        .err      (err),
        .err_code (err_code),
        .err_pulse(err_pulse),
        .cycles   (cycles)
    );

    typedef struct {
        int ph;
        int er;
        int code;
        int pulse;
        int cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    int m_track, m_prev, m_err, m_code, m_cyc, m_dwell;

    function automatic int decode(input bit [2:0] l);
        case (l)
            3'b000:  return 0;
            3'b100:  return 1;
            3'b110:  return 2;
            3'b001:  return 3;
            3'b010:  return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int succ(input int p);
        return (p == 4) ? 1 : p + 1;
    endfunction

    function automatic bit [2:0] pat(input int p);
        case (p)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_track = 0; m_prev = 0; m_err = 0; m_code = 0; m_cyc = 0; m_dwell = 0;
    endtask

    task automatic apply(input bit [2:0] l, input bit c);
        int cur, v;
        exp_t e;
        {red, amb, gre} = l;
        clr = c;
        cur = decode(l);
        v = 0;
        if (cur == 7) begin
            v = 1;
            m_track = 0;
        end else if (m_track == 0) begin
            if (cur <= 1) m_track = 1;
            else          v = 2;
        end else if (cur != m_prev && cur != succ(m_prev)) begin
            v = 2;
        end else if (m_prev == 4 && cur == 1) begin
            m_cyc = (m_cyc + 1) % 256;
        end
`ifdef TRAFFIC_MON_DWELL_CHECK_EN
        if (cur == 0 || cur == 7)  m_dwell = 0;
        else if (cur != m_prev)    m_dwell = 1;
        else if (m_dwell + 1 > MAXD) begin
            if (v == 0) v = 3;
            m_dwell = 1;
        end else                   m_dwell = m_dwell + 1;
`endif
        if (v != 0) begin
            if (m_err == 0 || c) m_code = v;
            m_err = 1;
        end else if (c) begin
            m_err = 0;
            m_code = 0;
        end
        m_prev = cur;
        e.ph = cur; e.er = m_err; e.code = m_code; e.pulse = (v != 0); e.cyc = m_cyc;
        q.push_back(e);
    endtask

    task automatic step(input bit [2:0] l, input bit c);
        @(negedge clk);
        apply(l, c);
    endtask

    // Reset lands mid-cycle, outputs are checked at once, then the first post-release
    // sample is issued on the same negedge as the release.
    task automatic do_reset(input bit [2:0] l, input bit c);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_phase", int'(phase), 0);
        check("rst_err", int'(err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_pulse", int'(err_pulse), 0);
        check("rst_cycles", int'(cycles), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(l, c);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("phase", int'(phase), e.ph);
                check("err", int'(err), e.er);
                check("err_code", int'(err_code), e.code);
                check("err_pulse", int'(err_pulse), e.pulse);
                check("cycles", int'(cycles), e.cyc);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        model_reset();
        do_reset(3'b000, 1'b0);
        step(3'b100, 0); step(3'b110, 0); step(3'b001, 0); step(3'b010, 0); step(3'b100, 0);

        step(3'b001, 0);
        step(3'b111, 0);

        step(3'b000, 1);
        step(3'b001, 0);
        step(3'b101, 1);

        do_reset(3'b000, 1'b0);
        step(3'b100, 0);
        for (int i = 0; i < 256; i++) begin
            step(3'b110, 0); step(3'b001, 0); step(3'b010, 0); step(3'b100, 0);
        end

        step(3'b110, 0);
        repeat (5) step(3'b001, 0);
        step(3'b010, 0);
        step(3'b100, 0);

        step(3'b110, 0);
        step(3'b001, 0);
        step(3'b001, 0);
        do_reset(3'b001, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int r, p;
            bit [2:0] l;
            bit c;
            p = (m_prev == 7) ? 0 : m_prev;
            r = $urandom_range(0, 9);
            if (r < 5)      l = pat(succ(p));
            else if (r < 8) l = pat(p);
            else            l = 3'($urandom_range(0, 7));
            c = ($urandom_range(0, 9) == 0);
            step(l, c);
        end

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter: MAX_DWELL, default 16, maximum consecutive cycles one lit phase may be held (range 2..255).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: red  input  1  red lamp from the traffic light generator.
REQ-005 Port: amb  input  1  amber lamp from the traffic light generator.
REQ-006 Port: gre  input  1  green lamp from the traffic light generator.
REQ-007 Port: clr  input  1  synchronous clear of the sticky error.
REQ-008 Port: phase  output  3  registered decoded phase: 0 DARK, 1 RED, 2 RED_AMB, 3 GREEN, 4 AMBER, 7 ILLEGAL.
REQ-009 Port: err  output  1  sticky error flag.
REQ-010 Port: err_code  output  2  first-error cause: 0 none, 1 illegal pattern, 2 illegal transition, 3 dwell violation.
REQ-011 Port: err_pulse  output  1  one-cycle strobe on every detected violation.
REQ-012 Port: cycles  output  8  count of completed light cycles.

Function
REQ-013 The lamp vector {red,amb,gre} SHALL be sampled on every rising clk edge; pattern decode: 000 DARK, 100 RED, 110 RED_AMB, 001 GREEN, 010 AMBER, any other ILLEGAL.
REQ-014 phase SHALL show the decode of the sample taken at the most recent edge (latency 1 cycle from lamp change).
REQ-015 FSM states: WAIT (no valid previous sample), TRACK (previous phase held in register).
REQ-016 WAIT -> TRACK on the first sampled DARK or RED; any other first sample SHALL flag an illegal transition (code 2) and stay in WAIT.
REQ-017 In TRACK, legal transitions: same->same, DARK->RED, RED->RED_AMB, RED_AMB->GREEN, GREEN->AMBER, AMBER->RED; all others SHALL flag code 2.
REQ-018 An ILLEGAL pattern SHALL flag code 1 (priority over code 2) and return the FSM to WAIT.
REQ-019 A violation SHALL assert err_pulse for exactly the one cycle following the offending sample edge and set err on the same edge.
REQ-020 err_code SHALL capture only the first violation after reset/clear; later violations SHALL pulse err_pulse but not alter err_code.
REQ-021 clr asserted at an edge SHALL zero err and err_code; if a violation is detected at that same edge, the violation SHALL win (err=1, err_code=new cause).
REQ-022 cycles SHALL increment by 1 on each legal AMBER->RED transition and wrap 255->0 without flag.
REQ-023 cycles SHALL be unaffected by errors and by clr.

Reset
REQ-024 rst_n low SHALL immediately force: FSM=WAIT, phase=0, err=0, err_code=0, err_pulse=0, cycles=0, dwell counter=0.
REQ-025 Reset asserted mid-cycle SHALL discard prior phase history; the first sample after release is treated per REQ-016.
REQ-026 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-027 Macro TRAFFIC_MON_DWELL_CHECK_EN: when defined, an 8-bit dwell counter SHALL count consecutive edges with unchanged non-DARK phase, reset to 1 on phase change, and flag code 3 when it would exceed MAX_DWELL, then restart at 1.
REQ-028 Without TRAFFIC_MON_DWELL_CHECK_EN, no dwell counter SHALL be synthesized, MAX_DWELL SHALL be ignored, and code 3 SHALL never be produced.

Verification
REQ-029 Reset, then lamps 000,100,110,001,010,100 one per cycle -> phase 0,1,2,3,4,1; err=0; cycles=1 after the final sample.
REQ-030 In TRACK at RED, apply 001 -> err_pulse one cycle, err=1, err_code=2; then apply 111 -> err_pulse again, err_code remains 2.
REQ-031 Error pending, clr=1 with a legal sample -> err=0, err_code=0; clr=1 coinciding with 101 -> err=1, err_code=1.
REQ-032 Drive 256 legal full cycles -> cycles returns to 0, err=0.
REQ-033 With macro defined and MAX_DWELL=4, hold GREEN for 5 samples -> err_code=3 at the 5th; without macro, same stimulus -> err=0.
REQ-034 Assert rst_n low between clock edges mid-GREEN -> all outputs zero immediately; release and apply 001 -> err_code=2.
